// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   UART transmit controller. A frame is one start bit, eight data bits
//   sent LSB first, an optional even-parity bit and one or two stop bits.
//   Each bit lasts CLKS_PER_BIT clocks. The parity bit comes from an
//   external generator that is fed from the latched payload outputs.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit, 2..65535
//   STOP_BITS     stop bits per frame, 1 or 2
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   tx_start      single-cycle frame request; accepted only when idle
//   tx_data_i     payload, sampled with tx_start
//   parity_en     parity request, sampled with tx_start
//   par_data_o    latched payload, to the parity generator
//   par_en_o      latched parity enable, to the parity generator
//   parity_bit_i  even parity of par_data_o (0 when par_en_o is 0)
//   tx_o          registered serial line, idle high
//   tx_busy       high from acceptance until the frame completes
//   tx_done       one-cycle pulse on the last stop-bit cycle
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data_i,
    input  logic       parity_en,
    output logic [7:0] par_data_o,
    output logic       par_en_o,
    input  logic       parity_bit_i,
    output logic       tx_o,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [15:0] LP_CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic        LP_STOP_LAST = (STOP_BITS == 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_nxt;
    logic        r_stop_idx;
    logic        w_stop_idx_nxt;
    logic [7:0]  r_data;
    logic [7:0]  w_data_nxt;
    logic        r_pen;
    logic        w_pen_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        r_armed;
    logic        w_bit_end;
    logic        w_last_stop;

    assign w_bit_end   = (r_cnt == LP_CNT_LAST);
    assign w_last_stop = (r_stop_idx == LP_STOP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_pen      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_data     <= w_data_nxt;
            r_pen      <= w_pen_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Low through reset and for the first edge after release, so a request
    // coinciding with a release less than one cycle old is not accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Next state and next register values. The line level is computed for
    // the state being entered, so tx_o changes exactly at bit boundaries.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = w_bit_end ? '0 : r_cnt + 16'd1;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_data_nxt     = r_data;
        w_pen_nxt      = r_pen;
        w_tx_nxt       = r_tx;
        case (r_state)
            IDLE: begin
                w_cnt_nxt      = '0;
                w_bit_idx_nxt  = '0;
                w_stop_idx_nxt = 1'b0;
                w_tx_nxt       = 1'b1;
                if (tx_start && r_armed) begin
                    w_state_nxt = START;
                    w_data_nxt  = tx_data_i;
                    w_pen_nxt   = parity_en;
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_data[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    // 3-bit index wraps 7 -> 0 on the last data bit
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        if (r_pen) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = parity_bit_i;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_tx_nxt = r_data[w_bit_idx_nxt];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (w_last_stop) begin
                        w_state_nxt    = IDLE;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                    w_tx_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign par_data_o = r_data;
    assign par_en_o   = r_pen;
    assign tx_o       = r_tx;
    assign tx_busy    = (r_state != IDLE);
    assign tx_done    = (r_state == STOP) && w_bit_end && w_last_stop;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//   Two controllers (one and two stop bits, four clocks per bit) each with
//   an ideal even-parity generator on their par_* outputs. Stimulus pushes
//   the expected frame into a scoreboard; per-instance monitors capture each
//   frame from tx_busy/tx_done and compare it with the popped expectation.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       pen;
        int         nbits;
        logic [11:0] bits;
        int         gap;
        bit         abort;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n0 = 1'b1, rst_n1 = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       pen0 = 1'b0, pen1 = 1'b0;
    logic [7:0] din0 = '0, din1 = '0;
    logic [7:0] pd0, pd1;
    logic       pe0, pe1, pb0, pb1;
    logic       tx0, tx1, busy0, busy1, done0, done1;

    // Ideal parity generator: even parity of the latched payload
    assign pb0 = pe0 ? ^pd0 : 1'b0;
    assign pb1 = pe1 ? ^pd1 : 1'b0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .tx_start(start0), .tx_data_i(din0),
        .parity_en(pen0), .par_data_o(pd0), .par_en_o(pe0),
        .parity_bit_i(pb0), .tx_o(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .tx_start(start1), .tx_data_i(din1),
        .parity_en(pen1), .par_data_o(pd1), .par_en_o(pe1),
        .parity_bit_i(pb1), .tx_o(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    function automatic logic g_tx(input int k);   return (k == 0) ? tx0 : tx1;       endfunction
    function automatic logic g_busy(input int k); return (k == 0) ? busy0 : busy1;   endfunction
    function automatic logic g_done(input int k); return (k == 0) ? done0 : done1;   endfunction
    function automatic logic g_rst(input int k);  return (k == 0) ? rst_n0 : rst_n1; endfunction
    function automatic logic [7:0] g_pd(input int k); return (k == 0) ? pd0 : pd1;   endfunction
    function automatic logic g_pe(input int k);   return (k == 0) ? pe0 : pe1;       endfunction
    function automatic int stop_bits(input int k); return (k == 0) ? 1 : 2;          endfunction

    // Reference frame: list of bit levels, each lasting CPB clocks
    function automatic exp_t model(input int k, input logic [7:0] d, input logic p,
                                   input int gap, input bit ab);
        exp_t e;
        int   n;
        e.k = k; e.data = d; e.pen = p; e.gap = gap; e.abort = ab; e.bits = '1;
        n = 0;
        e.bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            e.bits[n] = d[i]; n++;
        end
        if (p) begin
            e.bits[n] = ($countones(d) % 2) == 1; n++;
        end
        for (int s = 0; s < stop_bits(k); s++) begin
            e.bits[n] = 1'b1; n++;
        end
        e.nbits = n;
        return e;
    endfunction

    task automatic chk(input bit ok, input string name, input longint got, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic s, input logic [7:0] d, input logic p);
        if (k == 0) begin start0 = s; din0 = d; pen0 = p; end
        else        begin start1 = s; din1 = d; pen1 = p; end
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic p, input int gap, input bit ab);
        drive(k, 1'b1, d, p);
        sb_q.push_back(model(k, d, p, gap, ab));
        tick();
        drive(k, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (g_busy(k) !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk(n < 200, "idle_timeout", n, 200);
    endtask

    task automatic pulse_ignored(input int k);
        drive(k, 1'b1, 8'hAA, 1'($urandom));
        tick();
        drive(k, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic finish_frame(input int k, input logic q[$], input int cyc,
                                input logic [7:0] pd_ref, input logic pe_ref, input bit pd_bad,
                                input bit aborted, input int gap, input int idle_bad);
        exp_t e;
        int   bad;
        if (sb_q.size() == 0) begin
            chk(1'b0, "unexpected_frame", k, -1);
            return;
        end
        e = sb_q.pop_front();
        chk(e.k == k, "frame_instance", k, e.k);
        chk(aborted == e.abort, "frame_abort", aborted, e.abort);
        if (!e.abort) chk(cyc == e.nbits * CPB, "frame_len", cyc, e.nbits * CPB);
        bad = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i / CPB >= e.nbits) bad++;
            else if (q[i] !== e.bits[i / CPB]) bad++;
        end
        chk(bad == 0, "frame_wave_bad_cycles", bad, 0);
        chk(pd_ref == e.data, "par_data_o", pd_ref, e.data);
        chk(pe_ref == e.pen, "par_en_o", pe_ref, e.pen);
        chk(!pd_bad, "latched_stable", pd_bad, 0);
        chk(idle_bad == 0, "idle_line_bad_cycles", idle_bad, 0);
        if (e.gap >= 0) chk(gap == e.gap, "idle_gap", gap, e.gap);
    endtask

    task automatic monitor(input int k);
        logic       q[$];
        int         cyc = 0, idle_cnt = 0, gap = 0, idle_bad = 0;
        bit         in_f = 1'b0, pd_bad = 1'b0;
        logic [7:0] pd_ref = '0;
        logic       pe_ref = 1'b0;
        forever begin
            @(negedge clk);
            if (g_rst(k) !== 1'b1) begin
                if (in_f) finish_frame(k, q, cyc, pd_ref, pe_ref, pd_bad, 1'b1, gap, idle_bad);
                in_f = 1'b0; idle_cnt = 0; idle_bad = 0;
            end else if (!in_f) begin
                if (g_busy(k) === 1'b1) begin
                    in_f = 1'b1; gap = idle_cnt; cyc = 0; q.delete();
                    pd_ref = g_pd(k); pe_ref = g_pe(k); pd_bad = 1'b0;
                end else begin
                    idle_cnt++;
                    if (g_tx(k) !== 1'b1 || g_done(k) !== 1'b0) idle_bad++;
                end
            end
            if (in_f && g_rst(k) === 1'b1) begin
                if (g_busy(k) !== 1'b1) begin
                    finish_frame(k, q, cyc, pd_ref, pe_ref, pd_bad, 1'b1, gap, idle_bad);
                    in_f = 1'b0; idle_cnt = 0; idle_bad = 0;
                end else begin
                    q.push_back(g_tx(k));
                    cyc++;
                    if (g_pd(k) !== pd_ref || g_pe(k) !== pe_ref) pd_bad = 1'b1;
                    if (g_done(k) === 1'b1) begin
                        finish_frame(k, q, cyc, pd_ref, pe_ref, pd_bad, 1'b0, gap, idle_bad);
                        in_f = 1'b0; idle_cnt = 0; idle_bad = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        int r;
        int t;
        logic [7:0] d;
        logic p;
        fork
            monitor(0);
            monitor(1);
        join_none

        #1;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        #2;
        chk(tx0 === 1'b1, "rst_tx_o", tx0, 1);
        chk(busy0 === 1'b0, "rst_tx_busy", busy0, 0);
        chk(done0 === 1'b0, "rst_tx_done", done0, 0);
        chk(pd0 === 8'h00, "rst_par_data_o", pd0, 0);
        chk(pe0 === 1'b0, "rst_par_en_o", pe0, 0);
        chk(tx1 === 1'b1, "rst_tx_o_2stop", tx1, 1);
        chk(busy1 === 1'b0, "rst_tx_busy_2stop", busy1, 0);
        @(posedge clk);
        #2;
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        repeat (2) tick();

        // Directed frames, one stop bit
        send(0, 8'h55, 1'b1, -1, 1'b0);
        wait_idle(0);
        send(0, 8'h01, 1'b1, 1, 1'b0);
        wait_idle(0);
        tick();
        send(0, 8'hFF, 1'b0, 2, 1'b0);
        wait_idle(0);

        // Request in the middle of DATA must be ignored
        send(0, 8'hC3, 1'b1, 1, 1'b0);
        repeat (4 + 3 * CPB) tick();
        pulse_ignored(0);
        wait_idle(0);

        // Back-to-back: request in the first idle cycle after tx_done
        send(0, 8'h5A, 1'b1, 1, 1'b0);
        wait_idle(0);

        // Reset in the middle of DATA aborts the frame
        send(0, 8'h3C, 1'b1, 1, 1'b1);
        repeat (4 + 4 * CPB) tick();
        #2;
        rst_n0 = 1'b0;
        #1;
        chk(tx0 === 1'b1, "abort_tx_o", tx0, 1);
        chk(busy0 === 1'b0, "abort_tx_busy", busy0, 0);
        chk(done0 === 1'b0, "abort_tx_done", done0, 0);
        chk(pd0 === 8'h00, "abort_par_data_o", pd0, 0);
        @(posedge clk);
        #2;
        rst_n0 = 1'b1;
        drive(0, 1'b1, 8'hF0, 1'b1);
        tick();
        drive(0, 1'b0, 8'h00, 1'b0);
        chk(busy0 === 1'b0, "start_on_release_ignored", busy0, 0);
        tick();
        send(0, 8'h0F, 1'b0, -1, 1'b0);
        wait_idle(0);

        // Random frames, one stop bit
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 3);
            repeat (r) tick();
            d = 8'($urandom);
            p = 1'($urandom);
            send(0, d, p, r + 1, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                t = $urandom_range(1, 30);
                repeat (t) tick();
                pulse_ignored(0);
            end
            wait_idle(0);
        end

        // Two stop bits
        send(1, 8'h00, 1'b1, -1, 1'b0);
        wait_idle(1);
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(0, 3);
            repeat (r) tick();
            d = 8'($urandom);
            p = 1'($urandom);
            send(1, d, p, r + 1, 1'b0);
            wait_idle(1);
        end

        repeat (5) tick();
        chk(sb_q.size() == 0, "scoreboard_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
